// File: rtl/rv32i_types.sv
//==============================================================================
// Module      : rv32i_types (package)
// Description : Shared types for the RV32I memory-side blocks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rv32i_types;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUSY_A = 3'd1,
    ARB_BUSY_B = 3'd2,
    ARB_DONE_A = 3'd3,
    ARB_DONE_B = 3'd4
  } arb_state_t;

  // Wide enough for any supported data width; users slice to DATA_W/8.
  localparam logic [127:0] ARB_MASK_ALL = '1;

endpackage : rv32i_types

`default_nettype wire

// File: rtl/arb_starve_ctr.sv
//==============================================================================
// Module      : arb_starve_ctr
// Description : Saturating counter of consecutive B grants while A waits.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int c_cnt_w = $clog2(STARVE_MAX + 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_limit = (r_cnt >= c_cnt_w'(STARVE_MAX));

endmodule : arb_starve_ctr

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Merges instruction (A) and data (B) ports onto one memory port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_a,
  input  logic [ADDR_W-1:0]   address_a,
  output logic [DATA_W-1:0]   rdata_a,
  output logic                resp_a,
  input  logic                read_b,
  input  logic                write_b,
  input  logic [DATA_W/8-1:0] wmask_b,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic [DATA_W-1:0]   wdata_b,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                resp_b,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  localparam int                 c_mask_w   = DATA_W / 8;
  localparam logic [c_mask_w-1:0] c_mask_all = ARB_MASK_ALL[c_mask_w-1:0];

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic                w_req_b;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_at_limit;
  logic                w_busy;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [c_mask_w-1:0] r_mem_be;
  logic [DATA_W-1:0]   r_rdata_a;
  logic [DATA_W-1:0]   r_rdata_b;

  assign w_req_b = read_b | write_b;
  assign w_busy  = (r_state == ARB_BUSY_A) || (r_state == ARB_BUSY_B);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_req_b && (!read_a || !w_at_limit)) begin
          w_grant_b   = 1'b1;
          w_state_nxt = ARB_BUSY_B;
        end else if (read_a) begin
          w_grant_a   = 1'b1;
          w_state_nxt = ARB_BUSY_A;
        end
      end
      ARB_BUSY_A: if (mem_resp) w_state_nxt = ARB_DONE_A;
      ARB_BUSY_B: if (mem_resp) w_state_nxt = ARB_DONE_B;
      // DONE always falls back to IDLE so a held request is re-arbitrated fresh.
      ARB_DONE_A, ARB_DONE_B: w_state_nxt = ARB_IDLE;
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_mem_be      <= '0;
      r_rdata_a     <= '0;
      r_rdata_b     <= '0;
    end else begin
      if (w_grant_a) begin
        r_mem_read    <= 1'b1;
        r_mem_write   <= 1'b0;
        r_mem_address <= address_a;
        r_mem_be      <= c_mask_all;
      end else if (w_grant_b) begin
        // Simultaneous read_b/write_b resolves to a write.
        r_mem_read    <= ~write_b;
        r_mem_write   <= write_b;
        r_mem_address <= address_b;
        r_mem_wdata   <= wdata_b;
        r_mem_be      <= write_b ? wmask_b : c_mask_all;
      end else if (w_busy && mem_resp) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end
      if ((r_state == ARB_BUSY_A) && mem_resp) r_rdata_a <= mem_rdata;
      if ((r_state == ARB_BUSY_B) && mem_resp) r_rdata_b <= mem_rdata;
    end
  end

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_grant_b & read_a),
    .clr      (w_grant_a | (w_grant_b & ~read_a)),
    .at_limit (w_at_limit)
  );

  assign resp_a          = (r_state == ARB_DONE_A);
  assign resp_b          = (r_state == ARB_DONE_B);
  assign rdata_a         = r_rdata_a;
  assign rdata_b         = r_rdata_b;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_address     = r_mem_address;
  assign mem_wdata       = r_mem_wdata;
  assign mem_byte_enable = r_mem_be;

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter (STARVE_MAX = 2).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;
  import rv32i_types::*;

  localparam int c_max = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_a;
  logic [31:0] address_a;
  logic [31:0] rdata_a;
  logic        resp_a;
  logic        read_b;
  logic        write_b;
  logic [3:0]  wmask_b;
  logic [31:0] address_b;
  logic [31:0] wdata_b;
  logic [31:0] rdata_b;
  logic        resp_b;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int total = 0;
  int bad   = 0;
  int sc    = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (c_max)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .read_a          (read_a),
    .address_a       (address_a),
    .rdata_a         (rdata_a),
    .resp_a          (resp_a),
    .read_b          (read_b),
    .write_b         (write_b),
    .wmask_b         (wmask_b),
    .address_b       (address_b),
    .wdata_b         (wdata_b),
    .rdata_b         (rdata_b),
    .resp_b          (resp_b),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Starvation rule: B wins unless A is waiting and B has had c_max turns in a row.
  function automatic bit pred_b(input bit a_pend, input bit b_pend);
    return b_pend && (!a_pend || sc < c_max);
  endfunction

  task automatic note_grant(input bit is_b, input bit a_pend);
    if (is_b) sc = a_pend ? ((sc < c_max) ? sc + 1 : c_max) : 0;
    else      sc = 0;
  endtask

  task automatic wait_cmd(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (mem_read || mem_write) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic serve(input bit is_b, input bit is_wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] mask, input int lat,
                       input logic [31:0] rdv, input bit drop);
    bit seen;
    wait_cmd(seen);
    chk("cmd_seen", seen, 1);
    if (!seen) return;
    chk("cmd_addr", mem_address, addr);
    chk("cmd_rw", {mem_read, mem_write}, is_wr ? 2'b01 : 2'b10);
    chk("cmd_be", mem_byte_enable, is_wr ? mask : 4'hF);
    if (is_wr) chk("cmd_wdata", mem_wdata, wd);
    if (drop) begin
      if (is_b) begin
        address_b = $urandom;
        wdata_b   = $urandom;
      end else begin
        address_a = $urandom;
      end
    end
    for (int i = 0; i < lat; i++) begin
      step();
      chk("hold_addr", mem_address, addr);
      chk("hold_rw", {mem_read, mem_write}, is_wr ? 2'b01 : 2'b10);
      chk("hold_noresp", {resp_a, resp_b}, 2'b00);
    end
    mem_rdata = rdv;
    mem_resp  = 1'b1;
    step();
    mem_resp  = 1'b0;
    mem_rdata = $urandom;
    chk("resp_pair", {resp_a, resp_b}, is_b ? 2'b01 : 2'b10);
    chk("cmd_dropped", {mem_read, mem_write}, 2'b00);
    if (!is_b) chk("rdata_a", rdata_a, rdv);
    else if (!is_wr) chk("rdata_b", rdata_b, rdv);
    if (drop) begin
      if (is_b) begin
        read_b  = 1'b0;
        write_b = 1'b0;
      end else begin
        read_a = 1'b0;
      end
    end
    step();
    chk("resp_single", {resp_a, resp_b}, 2'b00);
    if (!is_b) chk("rdata_a_hold", rdata_a, rdv);
    else if (!is_wr) chk("rdata_b_hold", rdata_b, rdv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ra, rb, wr, both, first_b, seen;
    logic [31:0] aa, ab, wd;
    logic [3:0]  mk;
    bit [5:0]    order;

    rst = 1'b1; read_a = 0; address_a = 0; read_b = 0; write_b = 0; wmask_b = 0;
    address_b = 0; wdata_b = 0; mem_rdata = 0; mem_resp = 0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_outs", {mem_read, mem_write, resp_a, resp_b}, 4'b0000);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_be", mem_byte_enable, 4'h0);
    chk("rst_rdata", {rdata_a, rdata_b}, 64'h0);

    // A read alone
    read_a = 1; address_a = 32'h60;
    note_grant(0, 1);
    serve(0, 0, 32'h60, 32'h0, 4'h0, 3, 32'h0000_0013, 1);
    chk("t1_rdata_a", rdata_a, 32'h13);

    // A and B read together: B first, then A
    read_a = 1; address_a = 32'h100; read_b = 1; address_b = 32'h2000; wmask_b = 4'h3;
    note_grant(1, 1);
    serve(1, 0, 32'h2000, 32'h0, 4'h0, 1, $urandom, 1);
    note_grant(0, 1);
    serve(0, 0, 32'h100, 32'h0, 4'h0, 0, $urandom, 1);

    // B byte store
    write_b = 1; wmask_b = 4'b0100; address_b = 32'h104; wdata_b = 32'h00AB_0000;
    note_grant(1, 0);
    serve(1, 1, 32'h104, 32'h00AB_0000, 4'b0100, 2, $urandom, 1);

    // read_b and write_b both high resolves to one write
    read_b = 1; write_b = 1; wmask_b = 4'hF; address_b = 32'h200; wdata_b = 32'hDEAD_BEEF;
    note_grant(1, 0);
    serve(1, 1, 32'h200, 32'hDEAD_BEEF, 4'hF, 1, $urandom, 1);

    // Reset mid-transaction
    read_a = 1; address_a = 32'h60;
    wait_cmd(seen);
    chk("t5_cmd_seen", seen, 1);
    step();
    rst = 1'b1;
    step();
    chk("t5_rst_read", mem_read, 0);
    chk("t5_rst_resp", resp_a, 0);
    chk("t5_rst_state", dut.r_state, ARB_IDLE);
    read_a = 0; rst = 1'b0; sc = 0;
    step();
    chk("t5_idle_noresp", resp_a, 0);
    read_a = 1; address_a = 32'h64;
    note_grant(0, 1);
    serve(0, 0, 32'h64, 32'h0, 4'h0, 1, $urandom, 1);

    // Starvation cap with both ports held: B, B, A, B, B, A
    read_a = 1; address_a = 32'h100; read_b = 1; write_b = 0; address_b = 32'h2000;
    order = 6'b011011;
    for (int k = 0; k < 6; k++) begin
      serve(order[k], 0, order[k] ? 32'h2000 : 32'h100, 32'h0, 4'h0, 1, $urandom, 0);
    end
    read_a = 0; read_b = 0;
    step();
    chk("t4_idle", {mem_read, mem_write}, 2'b00);
    sc = 0;  // last grant in the sequence was A

    // Randomised traffic against the model
    for (int it = 0; it < 25; it++) begin
      ra = $urandom_range(0, 1);
      rb = $urandom_range(0, 1);
      if (!ra && !rb) ra = 1;
      aa = $urandom; ab = $urandom; wd = $urandom;
      wr = $urandom_range(0, 1);
      both = wr && ($urandom_range(0, 3) == 0);
      mk = 4'($urandom_range(1, 15));
      read_a = ra; address_a = aa;
      read_b = rb && (!wr || both); write_b = rb && wr;
      address_b = ab; wdata_b = wd; wmask_b = mk;
      first_b = pred_b(ra, rb);
      if (first_b) begin
        note_grant(1, ra);
        serve(1, wr, ab, wd, mk, $urandom_range(0, 3), $urandom, 1);
        if (ra) begin
          note_grant(0, 1);
          serve(0, 0, aa, 32'h0, 4'h0, $urandom_range(0, 3), $urandom, 1);
        end
      end else begin
        note_grant(0, 1);
        serve(0, 0, aa, 32'h0, 4'h0, $urandom_range(0, 3), $urandom, 1);
        if (rb) begin
          note_grant(1, 0);
          serve(1, wr, ab, wd, mk, $urandom_range(0, 3), $urandom, 1);
        end
      end
    end

    step();
    chk("final_idle", {mem_read, mem_write, resp_a, resp_b}, 4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter

`default_nettype wire
